wb_arbiter: RTL



---
 rtl/wb_arbiter_pkg.sv | 15 +
 rtl/wb_arbiter_rr_pick.sv | 34 +++
 rtl/wb_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared Wishbone widths and the arbiter state encoding.
//   WB_ADR_W / WB_DAT_W : slave-side address and data widths.
//   arb_state_e         : arbiter FSM states (idle, owner forwarded, draining).
package wb_arbiter_pkg;

   localparam int unsigned WB_ADR_W = 32;
   localparam int unsigned WB_DAT_W = 32;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_GRANTED,
      ARB_DRAIN
   } arb_state_e;

endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// wb_arbiter_rr_pick: combinational round-robin priority picker.
//   req_i     : one request bit per requester.
//   ptr_i     : index that has highest priority this cycle.
//   gnt_idx_o : first requesting index at or after ptr_i, wrapping.
//   valid_o   : high when any request is present.
module wb_arbiter_rr_pick #(
   parameter int unsigned NUM_MASTERS = 2,
   localparam int unsigned IdxW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
   input  logic [NUM_MASTERS-1:0] req_i,
   input  logic [IdxW-1:0]        ptr_i,
   output logic [IdxW-1:0]        gnt_idx_o,
   output logic                   valid_o
);

   always_comb begin
      int unsigned idx;
      gnt_idx_o = '0;
      valid_o   = 1'b0;
      idx       = 0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         // Walk from ptr_i upwards, wrapping; first hit wins.
         idx = 32'(ptr_i) + i;
         if (idx >= NUM_MASTERS) begin
            idx = idx - NUM_MASTERS;
         end
         if (!valid_o && req_i[IdxW'(idx)]) begin
            valid_o   = 1'b1;
            gnt_idx_o = IdxW'(idx);
         end
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin Wishbone B4 pipelined arbiter, NUM_MASTERS -> one slave.
//   clk_i, rst_i                  : clock, synchronous active-high reset.
//   m_cyc_i/m_stb_i/m_we_i        : per-master bus controls.
//   m_sel_i/m_adr_i/m_dat_i       : per-master byte selects, address, write data.
//   m_stall_o/m_ack_o             : per-master stall and ack (non-owners always stalled).
//   m_dat_o                       : slave read data broadcast, qualify with m_ack_o.
//   wb_*_o / wb_stall_i/wb_ack_i/wb_dat_i : slave-side port.
//   grant_o                       : current owner index.
// Ownership lasts for a whole cyc envelope; requests accepted but not yet acked are
// counted so that an owner dropping cyc early is drained before re-arbitration.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int unsigned NUM_MASTERS     = 2,
   parameter int unsigned MAX_OUTSTANDING = 4,
   localparam int unsigned IdxW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
   localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic [NUM_MASTERS-1:0]                m_cyc_i,
   input  logic [NUM_MASTERS-1:0]                m_stb_i,
   input  logic [NUM_MASTERS-1:0]                m_we_i,
   input  logic [NUM_MASTERS-1:0][3:0]           m_sel_i,
   input  logic [NUM_MASTERS-1:0][WB_ADR_W-1:0]  m_adr_i,
   input  logic [NUM_MASTERS-1:0][WB_DAT_W-1:0]  m_dat_i,
   output logic [NUM_MASTERS-1:0]                m_stall_o,
   output logic [NUM_MASTERS-1:0]                m_ack_o,
   output logic [WB_DAT_W-1:0]                   m_dat_o,
   output logic                                  wb_cyc_o,
   output logic                                  wb_stb_o,
   output logic                                  wb_we_o,
   output logic [3:0]                            wb_sel_o,
   output logic [WB_ADR_W-1:0]                   wb_adr_o,
   output logic [WB_DAT_W-1:0]                   wb_dat_o,
   input  logic                                  wb_stall_i,
   input  logic                                  wb_ack_i,
   input  logic [WB_DAT_W-1:0]                   wb_dat_i,
   output logic [IdxW-1:0]                       grant_o
);

   arb_state_e      state_q;
   logic [IdxW-1:0] owner_q;
   logic [IdxW-1:0] rr_ptr_q;
   logic [CntW-1:0] outstanding_q;
   logic [CntW-1:0] outstanding_d;

   logic [IdxW-1:0] pick_idx;
   logic            pick_valid;
   logic [IdxW-1:0] next_ptr;
   logic            at_max;
   logic            ack_valid;
   logic            accept;

   wb_arbiter_rr_pick #(
      .NUM_MASTERS (NUM_MASTERS)
   ) u_rr_pick (
      .req_i     (m_cyc_i),
      .ptr_i     (rr_ptr_q),
      .gnt_idx_o (pick_idx),
      .valid_o   (pick_valid)
   );

   assign at_max    = (outstanding_q == CntW'(MAX_OUTSTANDING));
   // Acks with nothing outstanding are dropped, never forwarded or counted.
   assign ack_valid = wb_ack_i & (outstanding_q != '0);
   assign accept    = wb_stb_o & ~wb_stall_i;
   assign next_ptr  = (owner_q == IdxW'(NUM_MASTERS - 1)) ? '0 : owner_q + IdxW'(1);
   assign m_dat_o   = wb_dat_i;
   assign grant_o   = owner_q;

   always_comb begin
      outstanding_d = outstanding_q;
      if (accept && !ack_valid) begin
         outstanding_d = outstanding_q + CntW'(1);
      end else if (!accept && ack_valid) begin
         outstanding_d = outstanding_q - CntW'(1);
      end
   end

   always_comb begin
      wb_cyc_o  = 1'b0;
      wb_stb_o  = 1'b0;
      wb_we_o   = 1'b0;
      wb_sel_o  = '0;
      wb_adr_o  = '0;
      wb_dat_o  = '0;
      m_stall_o = '1;
      m_ack_o   = '0;
      unique case (state_q)
         ARB_GRANTED: begin
            wb_cyc_o = 1'b1;
            // stb is also gated by the owner's cyc so a release cycle never issues.
            wb_stb_o = m_cyc_i[owner_q] & m_stb_i[owner_q] & ~at_max;
            wb_we_o  = m_we_i[owner_q];
            wb_sel_o = m_sel_i[owner_q];
            wb_adr_o = m_adr_i[owner_q];
            wb_dat_o = m_dat_i[owner_q];
            m_stall_o[owner_q] = wb_stall_i | at_max;
            m_ack_o[owner_q]   = ack_valid;
         end
         ARB_DRAIN: begin
            // Hold the envelope open and swallow the abandoned acks.
            wb_cyc_o = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= ARB_IDLE;
         owner_q       <= '0;
         rr_ptr_q      <= '0;
         outstanding_q <= '0;
      end else begin
         outstanding_q <= outstanding_d;
         case (state_q)
            ARB_IDLE: begin
               if (pick_valid) begin
                  owner_q <= pick_idx;
                  state_q <= ARB_GRANTED;
               end
            end
            ARB_GRANTED: begin
               if (!m_cyc_i[owner_q]) begin
                  rr_ptr_q <= next_ptr;
                  state_q  <= (outstanding_d == '0) ? ARB_IDLE : ARB_DRAIN;
               end
            end
            ARB_DRAIN: begin
               if (outstanding_d == '0) begin
                  state_q <= ARB_IDLE;
               end
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

endmodule
